slm_axil_cfg_sequencer: RTL and testbench

//  AXI4-Lite master that configures and self-checks the SimpleLogicModule register bank.
//  On start: writes NUM_REGS words, then reads them back and compares each against the value written.

---
 rtl/slm_pkg.sv | 21 ++
 rtl/slm_axil_cfg_sequencer_if.sv | 57 +++++
 rtl/slm_axil_cfg_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_slm_axil_cfg_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slm_pkg.sv
// rtl/slm_pkg.sv - shared state encoding and response/error codes for the AXI-Lite config sequencer
package slm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FINISH,
    FAIL
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_RESP     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/slm_axil_cfg_sequencer_if.sv
// rtl/slm_axil_cfg_sequencer_if.sv - AXI4-Lite channel bundle between the sequencer and the register bank
interface slm_axil_cfg_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/slm_axil_cfg_sequencer.sv
// rtl/slm_axil_cfg_sequencer.sv - AXI4-Lite master that writes a register bank, reads it back and reports the first error
module slm_axil_cfg_sequencer
  import slm_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int TIMEOUT    = 256
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           start,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_data,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [1:0]                     err_code,
  output logic [3:0]                     err_idx,
  slm_axil_cfg_sequencer_if.master       m_axi
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    pass_q, pass_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [3:0]              err_idx_q, err_idx_d;
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_REGS];

  logic                    load_shadow;
  logic                    fail;
  logic [1:0]              fail_code;
  logic                    timed;
  logic                    timeout;
  logic                    aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]   reg_addr;

  // Address and data derive from idx_q, which only moves between requests,
  // so they stay stable for as long as the matching VALID is high.
  assign reg_addr = ADDR_WIDTH'(BASE_ADDR + 4 * int'(idx_q));

  assign timed   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_RESP);
  assign timeout = (cnt_q == TIMEOUT_CNT);

  assign m_axi.awaddr  = reg_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi.wdata   = shadow_q[idx_q];
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi.bready  = (state_q == WR_RESP);
  assign m_axi.araddr  = reg_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_q == RD_REQ);
  assign m_axi.rready  = (state_q == RD_RESP);

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid && m_axi.wready;

  assign busy     = timed;
  assign done     = (state_q == FINISH) || (state_q == FAIL);
  assign pass     = pass_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    pass_d      = pass_q;
    err_code_d  = err_code_q;
    err_idx_d   = err_idx_q;
    load_shadow = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          load_shadow = 1'b1;
          idx_d       = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          pass_d      = 1'b0;
          err_code_d  = ERR_NONE;
          err_idx_d   = '0;
          state_d     = WR_REQ;
        end
      end

      WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      WR_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != RESP_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = RD_REQ;
          end else begin
            idx_d     = idx_q + 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      RD_REQ: begin
        if (m_axi.arready) begin
          state_d = RD_RESP;
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      RD_RESP: begin
        if (m_axi.rvalid) begin
          if (m_axi.rresp != RESP_OKAY) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else if (m_axi.rdata != shadow_q[idx_q]) begin
            fail      = 1'b1;
            fail_code = ERR_MISMATCH;
          end else if (idx_q == LAST_IDX) begin
            pass_d  = 1'b1;
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD_REQ;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end

      FINISH:  state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d    = FAIL;
      pass_d     = 1'b0;
      err_code_d = fail_code;
      err_idx_d  = 4'(idx_q);
    end

    // Phase counter restarts on every state entry and idles at zero outside the AXI phases.
    if (!timed || (state_d != state_q)) cnt_d = '0;
    else                                cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      pass_q     <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      pass_q     <= pass_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (load_shadow) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= cfg_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_slm_axil_cfg_sequencer.sv
// tb/tb_slm_axil_cfg_sequencer.sv - directed bench with an AXI-Lite memory slave for the config sequencer
module tb_slm_axil_cfg_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] cfg_data;
  logic         busy, done, pass;
  logic [1:0]   err_code;
  logic [3:0]   err_idx;

  int tests = 0;
  int fails = 0;

  // Slave configuration, written only by the stimulus block.
  bit rand_mode     = 1'b0;
  bit ar_hold       = 1'b0;
  int bresp_err_at  = -1;
  int rd_corrupt_at = -1;

  // Slave bookkeeping, written only by the posedge recorder.
  bit          aw_got, w_got, r_pend;
  bit          aw_wait, w_wait, ar_wait;
  logic [3:0]  aw_hold_a, ar_hold_a, aw_addr_l, ar_addr_l;
  logic [31:0] w_hold_d, w_data_l;
  logic [31:0] mem [16];
  logic [3:0]  wr_log [64];
  int wr_cnt = 0, rd_cnt = 0, w_first = 0, stab_err = 0, ar_high = 0;

  // Slave delay state, owned by the negedge driver.
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;

  always #5 clk = ~clk;

  slm_axil_cfg_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) m ();

  slm_axil_cfg_sequencer #(
    .NUM_REGS(4), .ADDR_WIDTH(4), .DATA_WIDTH(32), .BASE_ADDR(0), .TIMEOUT(256)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code), .err_idx(err_idx),
    .m_axi(m.master)
  );

  function automatic int pick(int lo, int hi);
    return rand_mode ? int'($urandom_range(hi, lo)) : 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 0; w_got = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (aw_wait && (m.awvalid !== 1'b1 || m.awaddr !== aw_hold_a)) stab_err++;
      if (w_wait && (m.wvalid !== 1'b1 || m.wdata !== w_hold_d)) stab_err++;
      if (ar_wait && (m.arvalid !== 1'b1 || m.araddr !== ar_hold_a)) stab_err++;
      aw_wait = m.awvalid && !m.awready; aw_hold_a = m.awaddr;
      w_wait  = m.wvalid && !m.wready;   w_hold_d  = m.wdata;
      ar_wait = m.arvalid && !m.arready; ar_hold_a = m.araddr;
      if (m.arvalid === 1'b1) ar_high++;
      if (m.awvalid && m.awready) begin
        if (w_got) w_first++;
        aw_got = 1; aw_addr_l = m.awaddr;
      end
      if (m.wvalid && m.wready) begin
        w_got = 1; w_data_l = m.wdata;
      end
      if (m.bvalid && m.bready) begin
        mem[int'(aw_addr_l >> 2)] = w_data_l;
        wr_log[wr_cnt % 64] = aw_addr_l;
        wr_cnt++;
        aw_got = 0; w_got = 0;
      end
      if (m.arvalid && m.arready) begin
        r_pend = 1; ar_addr_l = m.araddr; rd_cnt++;
      end
      if (m.rvalid && m.rready) r_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 2'b00;
      m.arready = 0; m.rvalid = 0; m.rresp = 2'b00; m.rdata = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (m.awvalid && !aw_got) begin
        if (aw_cnt == 0) aw_dly = pick(4, 7);
        m.awready = (aw_cnt >= aw_dly); aw_cnt++;
      end else begin m.awready = 0; aw_cnt = 0; end
      if (m.wvalid && !w_got) begin
        if (w_cnt == 0) w_dly = pick(0, 3);
        m.wready = (w_cnt >= w_dly); w_cnt++;
      end else begin m.wready = 0; w_cnt = 0; end
      if (aw_got && w_got) begin
        if (b_cnt == 0 && !m.bvalid) b_dly = pick(0, 7);
        if (b_cnt >= b_dly) begin
          m.bvalid = 1;
          m.bresp  = (wr_cnt == bresp_err_at) ? 2'b10 : 2'b00;
        end else b_cnt++;
      end else begin m.bvalid = 0; m.bresp = 2'b00; b_cnt = 0; end
      if (m.arvalid && !ar_hold && !r_pend) begin
        if (ar_cnt == 0) ar_dly = pick(0, 7);
        m.arready = (ar_cnt >= ar_dly); ar_cnt++;
      end else begin m.arready = 0; ar_cnt = 0; end
      if (r_pend) begin
        if (r_cnt == 0 && !m.rvalid) r_dly = pick(0, 7);
        if (r_cnt >= r_dly) begin
          if (!m.rvalid) m.rdata = ((rd_cnt - 1) == rd_corrupt_at) ? 32'h0000_DEAD : mem[int'(ar_addr_l >> 2)];
          m.rvalid = 1;
        end else r_cnt++;
      end else begin m.rvalid = 0; r_cnt = 0; m.rdata = '0; end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err_code"}, 32'(err_code), 0);
    check({tag, "_err_idx"}, 32'(err_idx), 0);
    check({tag, "_valids"}, {28'd0, m.awvalid, m.wvalid, m.arvalid, 1'b0}, 0);
    check({tag, "_readies"}, {30'd0, m.bready, m.rready}, 0);
    check({tag, "_addr_data"}, {m.wdata[15:0], 8'(m.awaddr), 8'(m.araddr)}, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  int n, wr0, rd0, wf0, st0, arh0;

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    next_cycle();

    // 1: zero-wait slave; done 17 cycles after the start cycle
    cfg_data = {32'd4, 32'd3, 32'd2, 32'd1};
    wr0 = wr_cnt; rd0 = rd_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    check("t1_awvalid", 32'(m.awvalid), 1);
    check("t1_wvalid", 32'(m.wvalid), 1);
    check("t1_wstrb_prot", {24'd0, m.wstrb, 1'b0, m.awprot}, 32'h000000F0);
    wait_done(n);
    check("t1_latency", n + 1, 17);
    check("t1_pass", 32'(pass), 1);
    check("t1_err_code", 32'(err_code), 0);
    check("t1_busy_at_done", 32'(busy), 0);
    check("t1_writes", wr_cnt - wr0, 4);
    check("t1_reads", rd_cnt - rd0, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_wr_addr", 32'(wr_log[wr0 + i]), 32'(4 * i));
      check("t1_mem", mem[i], 32'(i + 1));
    end
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    check("t1_start_at_done_busy", 32'(busy), 0);
    check("t1_pass_held", 32'(pass), 1);
    next_cycle();
    check("t1_start_at_done_idle", 32'(busy), 0);

    // 2: random ready/response delays, W always accepted before AW
    rand_mode = 1'b1;
    wr0 = wr_cnt; rd0 = rd_cnt; wf0 = w_first; st0 = stab_err;
    pulse_start();
    check("t2_pass_cleared", 32'(pass), 0);
    wait_done(n);
    check("t2_pass", 32'(pass), 1);
    check("t2_err_code", 32'(err_code), 0);
    check("t2_writes", wr_cnt - wr0, 4);
    check("t2_reads", rd_cnt - rd0, 4);
    check("t2_w_before_aw", w_first - wf0, 4);
    check("t2_valid_stable", stab_err - st0, 0);
    rand_mode = 1'b0;
    next_cycle();

    // 3: read of reg 2 corrupted
    rd0 = rd_cnt;
    rd_corrupt_at = rd_cnt + 2;
    pulse_start();
    wait_done(n);
    check("t3_pass", 32'(pass), 0);
    check("t3_err_code", 32'(err_code), 1);
    check("t3_err_idx", 32'(err_idx), 2);
    check("t3_reads", rd_cnt - rd0, 3);
    rd_corrupt_at = -1;
    next_cycle();
    check("t3_err_held", 32'(err_code), 1);

    // 4: SLVERR on the reg 1 write
    wr0 = wr_cnt; rd0 = rd_cnt;
    bresp_err_at = wr_cnt + 1;
    pulse_start();
    wait_done(n);
    check("t4_pass", 32'(pass), 0);
    check("t4_err_code", 32'(err_code), 2);
    check("t4_err_idx", 32'(err_idx), 1);
    check("t4_writes", wr_cnt - wr0, 2);
    check("t4_reads", rd_cnt - rd0, 0);
    bresp_err_at = -1;
    next_cycle();

    // 5: ARREADY never rises -> timeout after 256 cycles of ARVALID
    ar_hold = 1'b1;
    rd0 = rd_cnt; arh0 = ar_high;
    pulse_start();
    wait_done(n);
    check("t5_pass", 32'(pass), 0);
    check("t5_err_code", 32'(err_code), 3);
    check("t5_err_idx", 32'(err_idx), 0);
    check("t5_arvalid_cycles", ar_high - arh0, 256);
    check("t5_arvalid_dropped", 32'(m.arvalid), 0);
    check("t5_reads", rd_cnt - rd0, 0);
    ar_hold = 1'b0;
    next_cycle();

    // 6: reset inside WR_REQ, then a clean rerun with a start pulse while busy
    rand_mode = 1'b1;
    pulse_start();
    next_cycle();
    check("t6_in_wr_req", {30'd0, busy, m.awvalid}, 3);
    rst_n = 1'b0;
    #1;
    check_quiet("t6_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_mode = 1'b0;
    next_cycle();
    cfg_data = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    wr0 = wr_cnt;
    pulse_start();
    repeat (3) next_cycle();
    cfg_data = {4{32'hFFFF_FFFF}};
    pulse_start();
    check("t6_busy_start", 32'(busy), 1);
    wait_done(n);
    check("t6_latency", n + 5, 17);
    check("t6_pass", 32'(pass), 1);
    check("t6_writes", wr_cnt - wr0, 4);
    for (int i = 0; i < 4; i++) check("t6_mem", mem[i], 32'h1111_0000 + 32'(i));
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
